// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit holding the architectural HI/LO registers.
// Results are computed at issue into shadow registers and committed when the busy countdown expires.
module md_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        MDStart,
  input  logic [2:0]  MDOp,
  input  logic [31:0] MDOpA,
  input  logic [31:0] MDOpB,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state;
  logic        busy_r;
  logic [31:0] cnt;
  logic [31:0] hi_r, lo_r;
  logic [31:0] hi_sh, lo_sh;
  logic        wr_sh;

  logic        is_signed, a_neg, b_neg;
  logic [31:0] a_mag, b_mag, quot, rem, q_s, r_s;
  logic [63:0] prod, prod_s;

  // Sign-magnitude datapath: avoids the signed-overflow corner of 0x80000000 / -1,
  // which falls out naturally as magnitude 0x80000000 negated back to itself.
  always_comb begin
    is_signed = ~MDOp[0];
    a_neg     = is_signed & MDOpA[31];
    b_neg     = is_signed & MDOpB[31];
    a_mag     = a_neg ? (~MDOpA + 32'd1) : MDOpA;
    b_mag     = b_neg ? (~MDOpB + 32'd1) : MDOpB;
    prod      = {32'd0, a_mag} * {32'd0, b_mag};
    prod_s    = (a_neg ^ b_neg) ? (~prod + 64'd1) : prod;
    quot      = '0;
    rem       = '0;
    if (b_mag != '0) begin
      quot = a_mag / b_mag;
      rem  = a_mag % b_mag;
    end
    q_s = (a_neg ^ b_neg) ? (~quot + 32'd1) : quot;
    r_s = a_neg ? (~rem + 32'd1) : rem;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      busy_r <= 1'b0;
      cnt    <= '0;
      hi_r   <= '0;
      lo_r   <= '0;
      hi_sh  <= '0;
      lo_sh  <= '0;
      wr_sh  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (MDStart) begin
            case (MDOp)
              3'b000, 3'b001: begin
                hi_sh  <= prod_s[63:32];
                lo_sh  <= prod_s[31:0];
                wr_sh  <= 1'b1;
                cnt    <= 32'(MULT_CYCLES - 1);
                state  <= RUN;
                busy_r <= 1'b1;
              end
              3'b010, 3'b011: begin
                hi_sh  <= r_s;
                lo_sh  <= q_s;
                wr_sh  <= (MDOpB != '0);
                cnt    <= 32'(DIV_CYCLES - 1);
                state  <= RUN;
                busy_r <= 1'b1;
              end
              3'b100:  hi_r <= MDOpA;
              3'b101:  lo_r <= MDOpA;
              default: ;
            endcase
          end
        end
        RUN: begin
          if (cnt == '0) begin
            if (wr_sh) begin
              hi_r <= hi_sh;
              lo_r <= lo_sh;
            end
            state  <= IDLE;
            busy_r <= 1'b0;
          end else begin
            cnt <= cnt - 32'd1;
          end
        end
        default: begin
          state  <= IDLE;
          busy_r <= 1'b0;
        end
      endcase
    end
  end

  assign Busy = busy_r;
  assign HI   = hi_r;
  assign LO   = lo_r;

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed cases plus random ops against an arithmetic reference model.
module tb_md_unit;

  localparam int unsigned MC = 5;
  localparam int unsigned DC = 10;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        MDStart;
  logic [2:0]  MDOp;
  logic [31:0] MDOpA, MDOpB;
  logic        Busy;
  logic [31:0] HI, LO;

  int n_assert = 0;
  int n_fail   = 0;
  logic [31:0] hi_m, lo_m;

  md_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .rst_n(rst_n), .MDStart(MDStart), .MDOp(MDOp),
    .MDOpA(MDOpA), .MDOpB(MDOpB), .Busy(Busy), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Architectural effect of one accepted op on HI/LO.
  task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint      sq, sr;
    logic [63:0] up, ua, ub;
    case (op)
      3'd0: begin
        sq = longint'($signed(a)) * longint'($signed(b));
        {hi_m, lo_m} = sq;
      end
      3'd1: begin
        ua = {32'd0, a};
        ub = {32'd0, b};
        up = ua * ub;
        {hi_m, lo_m} = up;
      end
      3'd2: if (b != 0) begin
        sq = longint'($signed(a)) / longint'($signed(b));
        sr = longint'($signed(a)) % longint'($signed(b));
        lo_m = sq[31:0];
        hi_m = sr[31:0];
      end
      3'd3: if (b != 0) begin
        lo_m = a / b;
        hi_m = a % b;
      end
      3'd4: hi_m = a;
      3'd5: lo_m = a;
      default: ;
    endcase
  endtask

  function automatic int busy_len(input logic [2:0] op);
    if (op <= 3'd1) return int'(MC);
    if (op <= 3'd3) return int'(DC);
    return 0;
  endfunction

  // Drive a one-cycle strobe; returns at the negedge after the accepting edge.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    MDStart = 1'b1; MDOp = op; MDOpA = a; MDOpB = b;
    @(negedge clk);
    MDStart = 1'b0;
  endtask

  task automatic wait_busy(output int cyc);
    cyc = 0;
    while (Busy === 1'b1 && cyc < 200) begin
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int cyc;
    model(op, a, b);
    issue(op, a, b);
    wait_busy(cyc);
    chk({tag, "_busylen"}, 32'(cyc), 32'(busy_len(op)));
    chk({tag, "_hi"}, HI, hi_m);
    chk({tag, "_lo"}, LO, lo_m);
  endtask

  initial begin
    int cyc;
    logic [2:0]  rop;
    logic [31:0] ra, rb;
    logic [31:0] specials [4];
    specials[0] = 32'h0; specials[1] = 32'h1;
    specials[2] = 32'hFFFFFFFF; specials[3] = 32'h80000000;

    rst_n = 1'b0; MDStart = 1'b0; MDOp = '0; MDOpA = '0; MDOpB = '0;
    hi_m = '0; lo_m = '0;
    @(negedge clk); @(negedge clk);
    chk("reset_busy", {31'd0, Busy}, 32'd0);
    chk("reset_hi", HI, 32'd0);
    chk("reset_lo", LO, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // mthi then mtlo back to back
    MDStart = 1'b1; MDOp = 3'b100; MDOpA = 32'h12345678;
    @(negedge clk);
    chk("mthi_hi", HI, 32'h12345678);
    chk("mthi_busy", {31'd0, Busy}, 32'd0);
    MDOp = 3'b101; MDOpA = 32'hCAFEBABE;
    @(negedge clk);
    MDStart = 1'b0;
    chk("mtlo_lo", LO, 32'hCAFEBABE);
    chk("mtlo_hi_kept", HI, 32'h12345678);
    chk("mtlo_busy", {31'd0, Busy}, 32'd0);
    hi_m = 32'h12345678; lo_m = 32'hCAFEBABE;

    run_op("mult_neg", 3'd0, 32'hFFFFFFFD, 32'd5);
    chk("mult_neg_hi_const", HI, 32'hFFFFFFFF);
    chk("mult_neg_lo_const", LO, 32'hFFFFFFF1);
    run_op("multu", 3'd1, 32'hFFFFFFFF, 32'd2);
    chk("multu_hi_const", HI, 32'h00000001);
    chk("multu_lo_const", LO, 32'hFFFFFFFE);
    run_op("div_neg", 3'd2, 32'hFFFFFFF9, 32'd2);
    chk("div_neg_lo_const", LO, 32'hFFFFFFFD);
    chk("div_neg_hi_const", HI, 32'hFFFFFFFF);
    run_op("divu", 3'd3, 32'd7, 32'd2);
    chk("divu_lo_const", LO, 32'd3);
    chk("divu_hi_const", HI, 32'd1);
    run_op("div_ovf", 3'd2, 32'h80000000, 32'hFFFFFFFF);
    chk("div_ovf_lo_const", LO, 32'h80000000);
    chk("div_ovf_hi_const", HI, 32'h0);

    // divide by zero leaves preloaded HI/LO intact
    run_op("pre_hi", 3'd4, 32'hAAAA0000, 32'd0);
    run_op("pre_lo", 3'd5, 32'h00005555, 32'd0);
    run_op("div0", 3'd2, 32'd9, 32'd0);
    chk("div0_hi_const", HI, 32'hAAAA0000);
    chk("div0_lo_const", LO, 32'h00005555);

    // strobes while busy are ignored
    model(3'd0, 32'd1000, 32'hFFFFFFFE);
    issue(3'd0, 32'd1000, 32'hFFFFFFFE);
    cyc = (Busy === 1'b1) ? 1 : 0;
    @(negedge clk);
    if (Busy === 1'b1) cyc++;
    MDStart = 1'b1; MDOp = 3'b101; MDOpA = 32'h1;
    @(negedge clk);
    if (Busy === 1'b1) cyc++;
    MDOp = 3'b000; MDOpA = 32'd7; MDOpB = 32'd7;
    @(negedge clk);
    if (Busy === 1'b1) cyc++;
    MDStart = 1'b0;
    while (Busy === 1'b1 && cyc < 200) begin
      @(negedge clk);
      if (Busy === 1'b1) cyc++;
    end
    chk("ignore_busylen", 32'(cyc), 32'(MC));
    chk("ignore_hi", HI, hi_m);
    chk("ignore_lo", LO, lo_m);
    @(negedge clk);
    chk("ignore_no_restart", {31'd0, Busy}, 32'd0);

    // random ops against the model
    for (int i = 0; i < 40; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 3)] : 32'($urandom);
      rb  = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 3)] : 32'($urandom);
      if ($urandom_range(0, 2) == 0) rb = rb & 32'h0000FFFF;
      run_op($sformatf("rand%0d_op%0d", i, rop), rop, ra, rb);
    end

    // reset mid-divide discards the result
    issue(3'd3, 32'd100, 32'd7);
    @(negedge clk); @(negedge clk); @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    hi_m = '0; lo_m = '0;
    chk("rst_mid_busy", {31'd0, Busy}, 32'd0);
    chk("rst_mid_hi", HI, 32'd0);
    chk("rst_mid_lo", LO, 32'd0);
    repeat (15) @(negedge clk);
    chk("rst_after_hi", HI, hi_m);
    chk("rst_after_lo", LO, lo_m);
    chk("rst_after_busy", {31'd0, Busy}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Multi-cycle multiply/divide unit with architectural HI/LO registers for the pipelined MIPS core.
- Consumes the mult/div/mthi/mtlo operations issued from EX and holds the 64-bit {HI,LO} result.
- Provides HI/LO to the mfhi/mflo read path.
- Reports Busy so hazard logic can stall mult/div/mfhi/mflo/mthi/mtlo in ID until the result is committed.

Parameters:
MULT_CYCLES, 5, Busy cycles for mult/multu (>=1)
DIV_CYCLES, 10, Busy cycles for div/divu (>=1)

Ports:
clk  input  1  clock; all state changes on the rising edge
rst_n  input  1  synchronous reset, active low
MDStart  input  1  one-cycle issue strobe from EX
MDOp  input  3  000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo, 11x no-op
MDOpA  input  32  rs operand (dividend / multiplicand / mthi/mtlo source)
MDOpB  input  32  rt operand (divisor / multiplier)
Busy  output  1  registered; high while a mult/div is in flight
HI  output  32  HI register
LO  output  32  LO register

Behaviour:
- Reset: rst_n=0 sampled at a clock edge sets HI=0, LO=0, Busy=0, state=IDLE and counter=0. Reset wins over every other input, including mid-operation; an in-flight result is discarded.
- States:
  - IDLE: Busy=0.
  - RUN: Busy=1; down-counter active.
- IDLE, MDStart=1, MDOp mult/multu/div/divu:
  - Latch the operands and MDOp.
  - Load counter with MULT_CYCLES-1 or DIV_CYCLES-1.
  - Go to RUN; Busy rises on the next cycle.
- RUN: counter decrements each cycle. On the edge where counter==0:
  - Write HI/LO.
  - Return to IDLE.
  - Busy falls in the same edge.
  - Total: Busy high for exactly N cycles; new HI/LO visible on the cycle Busy first reads 0.
- IDLE, MDStart=1, mthi/mtlo:
  - HI (or LO) <= MDOpA on that edge; 1-cycle latency.
  - The other register is unchanged; Busy stays 0.
- MDStart=1 with a no-op code: ignored.
- MDStart=1 while Busy=1, any op: ignored. HI/LO and the running op are unaffected; hazard logic guarantees this never happens legally.
- mult (signed): {HI,LO} = sign-extended 64-bit product.
- multu: zero-extended 64-bit product.
- div (signed):
  - LO = quotient truncated toward zero.
  - HI = remainder with the sign of the dividend.
  - Overflow case 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- divu: LO = A/B, HI = A%B, unsigned.
- Divide by zero (div or divu, MDOpB=0):
  - Runs the full DIV_CYCLES with Busy behaving normally.
  - HI/LO are left unchanged at completion.
- The result may be computed iteratively or at issue into shadow registers. HI/LO must not change before the completion edge.
- HI/LO are direct register outputs with no bypass; the mfhi/mflo stall is driven by Busy.

Test Plan:
- Reset, then mthi 0x12345678 followed by mtlo 0xCAFEBABE on consecutive cycles -> HI=0x12345678, LO=0xCAFEBABE one cycle after each strobe; Busy stays 0.
- mult A=0xFFFFFFFD (-3), B=5 -> Busy high exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFF1. multu A=0xFFFFFFFF, B=2 -> HI=0x00000001, LO=0xFFFFFFFE.
- div A=0xFFFFFFF9 (-7), B=2 -> Busy 10 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu 7/2 -> LO=3, HI=1. div 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- Preload HI=0xAAAA0000, LO=0x5555; div A=9, B=0 -> Busy 10 cycles; HI/LO unchanged afterwards.
- During a mult, on busy cycle 2: strobe mtlo 0x1 and a second mult -> both ignored; final HI/LO equal the first product; Busy total 5 cycles.
- Start divu, assert rst_n=0 on busy cycle 4 -> next edge Busy=0, HI=LO=0; no later HI/LO update.
